interval_timer_ctrl: RTL and testbench

Controller that sequences a load/count-up counter into a programmable interval timer. It has a clock prescaler and one-shot or periodic modes, and raises a sticky interrupt with overrun detection. It sits between a register/config front-end and the counter datapath, and converts start/stop commands into load/count sequencing. Expiry is detected from the counter's "next count overflows" (all-ones) condition.

---
 rtl/interval_timer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : interval_timer_ctrl
//  Purpose  : Programmable interval timer controller. Sequences a load/count-up
//             counter through IDLE -> LOAD -> RUN, with a clock prescaler,
//             one-shot or periodic operation, a sticky interrupt and overrun
//             detection.
//  Ports    : clk_i, rst_i          clock / synchronous active-high reset
//             start_i, stop_i       start(restart) and abort commands
//             cfg_mode_i            0 = one-shot, 1 = periodic
//             cfg_period_i          N, expiry after N+1 ticks
//             cfg_prescale_i        P, one tick every P+1 clocks
//             irq_ack_i             clears irq_o and overrun_o
//             busy_o                high in LOAD or RUN
//             remaining_o           ticks left before the final tick
//             expire_o              one-cycle pulse per expiry
//             irq_o, overrun_o      sticky expiry / overrun flags
//  Revision : 1.0  initial release
// ============================================================================
module interval_timer_ctrl #(
   parameter int WORD_WIDTH  = 16,
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   cfg_mode_i,
   input  logic [WORD_WIDTH-1:0]  cfg_period_i,
   input  logic [PRESC_WIDTH-1:0] cfg_prescale_i,
   input  logic                   irq_ack_i,
   output logic                   busy_o,
   output logic [WORD_WIDTH-1:0]  remaining_o,
   output logic                   expire_o,
   output logic                   irq_o,
   output logic                   overrun_o
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_load = 2'd1;
   localparam logic [1:0] c_run  = 2'd2;

   localparam logic [WORD_WIDTH-1:0]  c_cnt_one = WORD_WIDTH'(1);
   localparam logic [PRESC_WIDTH-1:0] c_psc_one = PRESC_WIDTH'(1);

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic                   r_mode;
   logic [WORD_WIDTH-1:0]  r_period;
   logic [PRESC_WIDTH-1:0] r_prescale;
   logic [WORD_WIDTH-1:0]  r_count;
   logic [PRESC_WIDTH-1:0] r_pcount;
   logic                   r_expire;
   logic                   r_irq;
   logic                   r_overrun;

   logic w_capture;
   logic w_hold;
   logic w_tick;
   logic w_expiry;
   logic w_busy;

   // A start without stop captures config in any state (start or restart).
   assign w_capture = start_i & ~stop_i;
   // Neither command present: LOAD/RUN proceed with their normal work.
   assign w_hold    = ~start_i & ~stop_i;
   assign w_tick    = (r_state == c_run) && (r_pcount == r_prescale);
   // The counter counts up from ~N; the tick taken at all-ones is the final one.
   // Commands outrank expiry, so a stop/restart on that edge suppresses it.
   assign w_expiry  = w_tick && (&r_count) && w_hold;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle: begin
            if (w_capture) w_state_nxt = c_load;
         end
         c_load: begin
            if (stop_i)       w_state_nxt = c_idle;
            else if (start_i) w_state_nxt = c_load;
            else              w_state_nxt = c_run;
         end
         c_run: begin
            if (stop_i)                   w_state_nxt = c_idle;
            else if (start_i)             w_state_nxt = c_load;
            else if (w_expiry && !r_mode) w_state_nxt = c_idle;
            else                          w_state_nxt = c_run;
         end
         default: w_state_nxt = c_idle;
      endcase
   end

   // ------------------------------------------------------------------
   // Config capture, counter / prescaler datapath and interrupt flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mode     <= 1'b0;
         r_period   <= '0;
         r_prescale <= '0;
         r_count    <= '0;
         r_pcount   <= '0;
         r_expire   <= 1'b0;
         r_irq      <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_capture) begin
            r_mode     <= cfg_mode_i;
            r_period   <= cfg_period_i;
            r_prescale <= cfg_prescale_i;
         end

         if (r_state == c_load && w_hold) begin
            r_count  <= ~r_period;
            r_pcount <= '0;
         end else if (r_state == c_run && w_hold) begin
            if (w_tick) begin
               r_pcount <= '0;
               // Periodic reload happens on the expiry edge itself so the
               // period stays exact (no extra LOAD cycle).
               r_count  <= (w_expiry && r_mode) ? ~r_period : r_count + c_cnt_one;
            end else begin
               r_pcount <= r_pcount + c_psc_one;
            end
         end

         r_expire  <= w_expiry;
         // Set wins over a simultaneous acknowledge.
         r_irq     <= w_expiry | (r_irq & ~irq_ack_i);
         // An acknowledge on the expiry edge means the previous event was
         // serviced in time, so it is not an overrun.
         r_overrun <= (w_expiry & r_irq & ~irq_ack_i) | (r_overrun & ~irq_ack_i);
      end
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin
      w_busy      = (r_state != c_idle);
      busy_o      = w_busy;
      remaining_o = w_busy ? ~r_count : '0;
      expire_o    = r_expire;
      irq_o       = r_irq;
      overrun_o   = r_overrun;
   end

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_interval_timer_ctrl
//  Purpose  : Self-checking bench for interval_timer_ctrl (WORD_WIDTH=4,
//             PRESC_WIDTH=2). A behavioural model predicts the outputs after
//             every clock edge and queues them; a monitor compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interval_timer_ctrl;

   localparam int WORD_WIDTH  = 4;
   localparam int PRESC_WIDTH = 2;
   localparam int c_wmask     = (1 << WORD_WIDTH) - 1;
   localparam int c_pmask     = (1 << PRESC_WIDTH) - 1;

   logic                   clk_i = 1'b0;
   logic                   rst_i = 1'b1;
   logic                   start_i = 1'b0;
   logic                   stop_i = 1'b0;
   logic                   cfg_mode_i = 1'b0;
   logic [WORD_WIDTH-1:0]  cfg_period_i = '0;
   logic [PRESC_WIDTH-1:0] cfg_prescale_i = '0;
   logic                   irq_ack_i = 1'b0;
   logic                   busy_o;
   logic [WORD_WIDTH-1:0]  remaining_o;
   logic                   expire_o;
   logic                   irq_o;
   logic                   overrun_o;

   interval_timer_ctrl #(
      .WORD_WIDTH  (WORD_WIDTH),
      .PRESC_WIDTH (PRESC_WIDTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .stop_i         (stop_i),
      .cfg_mode_i     (cfg_mode_i),
      .cfg_period_i   (cfg_period_i),
      .cfg_prescale_i (cfg_prescale_i),
      .irq_ack_i      (irq_ack_i),
      .busy_o         (busy_o),
      .remaining_o    (remaining_o),
      .expire_o       (expire_o),
      .irq_o          (irq_o),
      .overrun_o      (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int busy;
      int rem;
      int chk_rem;
      int expire;
      int irq;
      int ovr;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Behavioural model: phase = clocks since the last tick, rem = ticks left
   // before the final tick. States: 0 idle, 1 load, 2 run.
   int m_st = 0, m_mode = 0, m_n = 0, m_p = 0;
   int m_rem = 0, m_phase = 0, m_irq = 0, m_ovr = 0;

   task automatic chk(input string name, input int act, input int expv);
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic sp, input logic md,
                       input int n, input int p, input logic ack);
      exp_t e;
      int   expd;
      rst_i          = rst;
      start_i        = st;
      stop_i         = sp;
      cfg_mode_i     = md;
      cfg_period_i   = WORD_WIDTH'(n & c_wmask);
      cfg_prescale_i = PRESC_WIDTH'(p & c_pmask);
      irq_ack_i      = ack;

      expd = 0;
      if (rst) begin
         m_st = 0; m_mode = 0; m_n = 0; m_p = 0;
         m_rem = 0; m_phase = 0; m_irq = 0; m_ovr = 0;
      end else begin
         if (m_st != 0 && sp) begin
            m_st = 0;
         end else if (st && !sp) begin
            m_mode = int'(md); m_n = n & c_wmask; m_p = p & c_pmask;
            m_st = 1;
         end else if (m_st == 1) begin
            m_rem = m_n; m_phase = 0; m_st = 2;
         end else if (m_st == 2) begin
            if (m_phase == m_p) begin
               m_phase = 0;
               if (m_rem == 0) begin
                  expd = 1;
                  if (m_mode == 1) m_rem = m_n;
                  else             m_st = 0;
               end else begin
                  m_rem = m_rem - 1;
               end
            end else begin
               m_phase = m_phase + 1;
            end
         end
         m_ovr = ((expd == 1 && m_irq == 1 && !ack) || (m_ovr == 1 && !ack)) ? 1 : 0;
         m_irq = (expd == 1 || (m_irq == 1 && !ack)) ? 1 : 0;
      end

      e.busy    = (m_st != 0) ? 1 : 0;
      // In LOAD the counter holds a stale value; only RUN and IDLE are defined.
      e.chk_rem = (m_st != 1) ? 1 : 0;
      e.rem     = (m_st == 2) ? m_rem : 0;
      e.expire  = expd;
      e.irq     = m_irq;
      e.ovr     = m_ovr;

      @(posedge clk_i);
      sb_q.push_back(e);
      #1;
   endtask

   // Idle cycles with scrambled config inputs (must be ignored); ack follows
   // the model's irq when ack_irq is set.
   task automatic idle(input int cycles, input logic ack_irq);
      for (int i = 0; i < cycles; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), ack_irq && (m_irq == 1));
      end
   endtask

   // Monitor: compare each queued expectation half a cycle after its edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            chk("busy_o", int'(busy_o), e.busy);
            if (e.chk_rem == 1) chk("remaining_o", int'(remaining_o), e.rem);
            chk("expire_o", int'(expire_o), e.expire);
            chk("irq_o", int'(irq_o), e.irq);
            chk("overrun_o", int'(overrun_o), e.ovr);
         end
      end
   end

   initial begin
      int r;
      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 5, 2, 1'b0);
      idle(2, 1'b0);

      // One-shot N=3 P=0
      step(1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0);
      idle(8, 1'b0);

      // Periodic N=3 P=1, acking each expiry
      step(1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 1'b1);
      idle(30, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);

      // Periodic N=0 P=0: overrun without ack, then ack during expiry
      step(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
      idle(4, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 7, 3, 1'b1);
      idle(3, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

      // One-shot N=10, stop together with start at k+4
      step(1'b0, 1'b1, 1'b0, 1'b0, 10, 0, 1'b0);
      idle(3, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 10, 0, 1'b0);
      idle(3, 1'b0);

      // Restart: N=10 running, restart with N=2 at k+6
      step(1'b0, 1'b1, 1'b0, 1'b0, 10, 0, 1'b1);
      idle(5, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0);
      idle(8, 1'b0);

      // Boundary N=all-ones, P=0 one-shot, then periodic interrupted by reset
      step(1'b0, 1'b1, 1'b0, 1'b0, 15, 0, 1'b1);
      idle(20, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 15, 0, 1'b1);
      idle(10, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(20, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 199));
         step(1'(r == 0), 1'(r >= 1 && r <= 8), 1'(r >= 8 && r <= 11),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
      end
      idle(3, 1'b0);

      // Drain the scoreboard
      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk_i);
      #1;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
